// File: rtl/wb_bram_ctrl.sv
// rtl/wb_bram_ctrl.sv - Wishbone slave to single-port BRAM bridge with programmable wait delay
module wb_bram_ctrl #(
  parameter int          DELAYS    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_a,
  output logic [31:0] bram_di,
  input  logic [31:0] bram_do
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [7:0] DELAYS_C = 8'(DELAYS);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        hit;
  logic        req;

  assign hit = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign req = wbs_cyc_i & wbs_stb_i & hit;

  // BRAM address/data always come from the request latches, so they stay stable for the whole transaction
  assign bram_a  = {2'b00, adr_q};
  assign bram_di = dat_q;

  // State, wait counter and request latches; latches load only when a hit is accepted in IDLE
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= 8'd0;
      adr_q <= 30'd0;
      we_q  <= 1'b0;
      sel_q <= 4'd0;
      dat_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        adr_q <= wbs_adr_i[31:2];
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
      end
    end
  end

  // Next-state and per-state outputs; the BRAM is touched only in ACCESS, the bus only in ACK
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bram_en   = 1'b0;
    bram_we   = 4'd0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = 32'd0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = DELAYS_C;
          state_nxt = (DELAYS_C != 8'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          // Master gave up before the access: drop it without touching the BRAM
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt <= 8'd1) begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        bram_en   = 1'b1;
        bram_we   = sel_q & {4{we_q}};
        state_nxt = ACK;
      end
      ACK: begin
        wbs_ack_o = wbs_cyc_i & wbs_stb_i;
        wbs_dat_o = we_q ? 32'd0 : bram_do;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb/tb_wb_bram_ctrl.sv - Self-checking bench for wb_bram_ctrl (DELAYS=10 and DELAYS=0 instances)
module tb_wb_bram_ctrl;

  localparam int D0 = 10;
  localparam int D1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            mem_clr;
  logic [1:0]      cyc;
  logic [1:0]      stb;
  logic [1:0]      we;
  logic [1:0][3:0] sel;
  logic [1:0][31:0] adr;
  logic [1:0][31:0] dat;
  wire  [1:0]      ack;
  wire  [1:0][31:0] dato;
  wire  [1:0]      en;
  wire  [1:0][3:0] bwe;
  wire  [1:0][31:0] ba;
  wire  [1:0][31:0] bdi;
  logic [1:0][31:0] bdo;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_bram_ctrl #(
      .DELAYS   ((g == 0) ? D0 : D1),
      .BASE_ADDR(32'h3800_0000),
      .ADDR_MASK(32'hFFC0_0000)
    ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs_cyc_i(cyc[g]),
      .wbs_stb_i(stb[g]),
      .wbs_we_i (we[g]),
      .wbs_sel_i(sel[g]),
      .wbs_adr_i(adr[g]),
      .wbs_dat_i(dat[g]),
      .wbs_ack_o(ack[g]),
      .wbs_dat_o(dato[g]),
      .bram_en  (en[g]),
      .bram_we  (bwe[g]),
      .bram_a   (ba[g]),
      .bram_di  (bdi[g]),
      .bram_do  (bdo[g])
    );
  end

  // Behavioural single-port BRAM per instance: byte enables, registered read, output 0 after a disabled edge
  logic [31:0] mem [2][64];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_clr) begin
        for (int w = 0; w < 64; w++) mem[u][w] <= 32'd0;
        bdo[u] <= 32'd0;
      end else if (en[u]) begin
        bdo[u] <= mem[u][ba[u][5:0]];
        for (int b = 0; b < 4; b++)
          if (bwe[u][b]) mem[u][ba[u][5:0]][8*b +: 8] <= bdi[u][8*b +: 8];
      end else begin
        bdo[u] <= 32'd0;
      end
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Transaction-level model: expected word contents and the cycles of the access and the ack
  logic [31:0] exp_mem [2][64];
  int          exp_acc [2];
  int          exp_ack [2];
  logic [3:0]  exp_wev [2];
  logic [31:0] exp_a   [2];
  logic [31:0] exp_di  [2];
  logic [31:0] exp_rdv [2];
  bit          exp_isw [2];
  bit          chk_on = 1'b0;

  function automatic int dly(input int u);
    return (u == 0) ? D0 : D1;
  endfunction

  // Per-cycle comparison of every DUT output against the model
  bit e_en, e_ack;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++) begin
        e_en  = (cyc_n == exp_acc[u]);
        e_ack = (cyc_n == exp_ack[u]) && cyc[u] && stb[u];
        chk($sformatf("u%0d bram_en", u), 32'(en[u]), 32'(e_en));
        chk($sformatf("u%0d bram_we", u), 32'(bwe[u]), e_en ? 32'(exp_wev[u]) : 32'd0);
        if (e_en) begin
          chk($sformatf("u%0d bram_a", u), ba[u], exp_a[u]);
          chk($sformatf("u%0d bram_di", u), bdi[u], exp_di[u]);
        end
        chk($sformatf("u%0d ack", u), 32'(ack[u]), 32'(e_ack));
        chk($sformatf("u%0d dat_o", u), dato[u],
            ((cyc_n == exp_ack[u]) && !exp_isw[u]) ? exp_rdv[u] : 32'd0);
      end
    end
  end

  task automatic drive(input int u, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit expect_access);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; sel[u] = s; adr[u] = a; dat[u] = d;
    exp_isw[u] = w;
    exp_wev[u] = w ? s : 4'd0;
    exp_a[u]   = {2'b00, a[31:2]};
    exp_di[u]  = d;
    exp_rdv[u] = exp_mem[u][a[7:2]];
    exp_acc[u] = expect_access ? cyc_n + dly(u) + 1 : -1;
    exp_ack[u] = expect_access ? cyc_n + dly(u) + 2 : -1;
  endtask

  task automatic xfer(input int u, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input bit keep, output logic [31:0] rd, output int ackc);
    int  c;
    bit  got;
    @(posedge clk); #1;
    c = cyc_n;
    drive(u, w, s, a, d, 1'b1);
    got = 1'b0; rd = 32'd0; ackc = -1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (ack[u]) begin
        got = 1'b1; rd = dato[u]; ackc = cyc_n;
      end
    end
    chk($sformatf("u%0d ack seen", u), 32'(got), 32'd1);
    if (got) chk($sformatf("u%0d latency", u), 32'(ackc - c), 32'(dly(u) + 2));
    if (got && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[u][a[7:2]][8*b +: 8] = d[8*b +: 8];
    if (!keep) begin
      @(posedge clk); #1;
      cyc[u] = 1'b0; stb[u] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ack"}, 32'(ack[0]), 32'd0);
    chk({nm, " dat_o"}, dato[0], 32'd0);
    chk({nm, " en"}, 32'(en[0]), 32'd0);
    chk({nm, " we"}, 32'(bwe[0]), 32'd0);
    chk({nm, " a"}, ba[0], 32'd0);
    chk({nm, " di"}, bdi[0], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int ak, ak1, ak2;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 64; w++) exp_mem[u][w] = 32'd0;
      exp_acc[u] = -1; exp_ack[u] = -1; exp_wev[u] = 4'd0;
      exp_a[u] = 32'd0; exp_di[u] = 32'd0; exp_rdv[u] = 32'd0; exp_isw[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0; chk_on = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Write then read, DELAYS=10
    xfer(0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b0, rd, ak);
    xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 1'b0, rd, ak);
    chk("readback deadbeef", rd, 32'hDEAD_BEEF);

    // Byte lanes
    xfer(0, 1'b1, 4'hF, 32'h3800_0014, 32'h1122_3344, 1'b0, rd, ak);
    xfer(0, 1'b1, 4'b0101, 32'h3800_0014, 32'hAABB_CCDD, 1'b0, rd, ak);
    xfer(0, 1'b0, 4'hF, 32'h3800_0014, 32'h0, 1'b0, rd, ak);
    chk("byte lanes", rd, 32'h11BB_33DD);

    // Write with no lanes selected still acks and changes nothing
    xfer(0, 1'b1, 4'h0, 32'h3800_0014, 32'hFFFF_FFFF, 1'b0, rd, ak);
    xfer(0, 1'b0, 4'hF, 32'h3800_0014, 32'h0, 1'b0, rd, ak);
    chk("sel zero", rd, 32'h11BB_33DD);

    // Address miss held for 20 cycles
    @(posedge clk); #1;
    drive(0, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b0);
    repeat (20) @(posedge clk);
    #1 cyc[0] = 1'b0; stb[0] = 1'b0;

    // Abort in WAIT cycle 5 of a write
    @(posedge clk); #1;
    drive(0, 1'b1, 4'hF, 32'h3800_0010, 32'h5555_5555, 1'b0);
    repeat (5) @(posedge clk);
    #1 cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (15) @(posedge clk);
    xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 1'b0, rd, ak);
    chk("abort readback", rd, 32'hDEAD_BEEF);

    // DELAYS=0, back-to-back reads
    xfer(1, 1'b1, 4'hF, 32'h3800_0000, 32'h0123_4567, 1'b0, rd, ak);
    xfer(1, 1'b1, 4'hF, 32'h3800_0004, 32'h89AB_CDEF, 1'b0, rd, ak);
    xfer(1, 1'b0, 4'hF, 32'h3800_0000, 32'h0, 1'b1, rd, ak1);
    chk("b2b read0", rd, 32'h0123_4567);
    xfer(1, 1'b0, 4'hF, 32'h3800_0004, 32'h0, 1'b0, rd, ak2);
    chk("b2b read1", rd, 32'h89AB_CDEF);
    chk("b2b ack spacing", 32'(ak2 - ak1), 32'd3);

    // Reset during WAIT of a write
    @(posedge clk); #1;
    drive(0, 1'b1, 4'hF, 32'h3800_0020, 32'hCAFE_F00D, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst wait");
    @(posedge clk); #1;
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    xfer(0, 1'b0, 4'hF, 32'h3800_0020, 32'h0, 1'b0, rd, ak);
    chk("rst word unchanged", rd, 32'h0);
    xfer(0, 1'b1, 4'hF, 32'h3800_0020, 32'h1234_5678, 1'b0, rd, ak);
    xfer(0, 1'b0, 4'hF, 32'h3800_0020, 32'h0, 1'b0, rd, ak);
    chk("post reset rw", rd, 32'h1234_5678);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
